store_buffer: RTL and testbench
===============================

# store_buffer

Posted-write buffer between the single-cycle ARM core's data-memory port and a slower, handshaked data memory. Stores from the core are accepted in one cycle and queued, then drained in order to memory. Loads hit in the buffer are forwarded combinationally. Loads that miss stall the core until memory returns the word.

## Interface
Parameters:
- DEPTH, 4, number of store entries; power of two, ≥2
- AW, 32, byte-address width
- DW, 32, data width

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; state clears on any rising clk edge with reset==0
- MemWrite  in  1  core store request this cycle
- MemRead  in  1  core load request this cycle; ignored when MemWrite==1
- DataAdr  in  AW  core byte address; bits [1:0] ignored (word-aligned)
- WriteData  in  DW  core store data
- ReadData  out  DW  load data to core
- Stall  out  1  core must hold PC and all outputs this cycle
- drained  out  1  buffer empty and memory port idle
- mem_req  out  1  memory transaction valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  word address, {addr[AW-1:2], 2'b00}
- mem_wdata  out  DW  write data
- mem_ack  in  1  memory completes transaction; meaningful only when mem_req==1
- mem_rdata  in  DW  read data; valid in the mem_ack cycle of a read

## Operation
- Storage: circular FIFO of DEPTH entries {word address, data}. Uses head and tail pointers plus count ($clog2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Store accept: when MemWrite & (count<DEPTH), push at tail.
- Store when full: when MemWrite & count==DEPTH, Stall=1 and nothing is pushed, even if mem_ack pops in the same cycle. The store is accepted on the following cycle.
- Forwarding (load): compare DataAdr[AW-1:2] against all valid entries, including the head while it is in flight.
  - Youngest match wins.
  - On a hit: ReadData = entry data, Stall=0, no memory access.
- Load miss: Stall=1 until the read completes.
  - ReadData = mem_rdata in the read's mem_ack cycle, where Stall=0.
  - On a miss ReadData = 0 in all other cycles; with no load, ReadData = 0.
- Memory-port FSM, states IDLE, WRITE, READ:
  - IDLE: if a load miss is present, go to READ and latch the load address. Else if count>0, go to WRITE. Else stay in IDLE.
  - WRITE: mem_req=1, mem_we=1, addr/data taken from the head entry and held stable. On mem_ack: pop the head, then apply the IDLE decision using the post-pop count. If the core is stalled on a load miss, READ takes priority over further draining.
  - READ: mem_req=1, mem_we=0, mem_addr = latched address. On mem_ack: go to WRITE if count>0, else IDLE.
  - Back-to-back transactions are allowed: mem_req may stay high across an ack with a new payload the next cycle.
- Outputs are registered from the state and head entry: mem_req = (state≠IDLE); mem_wdata = head data in WRITE, 0 otherwise.
- drained = (count==0) & (state==IDLE).
- Stall and ReadData are combinational from the core inputs, buffer contents and mem_ack.

## Timing
- Reset values (after the first edge with reset==0): state IDLE, count 0, head=tail=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, drained=1. Stall=0 and ReadData=0 while reset==0.
- A store pushed at edge N can appear on mem_req at edge N+1 at the earliest, when the buffer is empty and the FSM is IDLE.
- A load that hits the buffer completes in 0 cycles (same cycle as the request).
- Minimum load-miss latency from an idle port:
  - Cycle 0: Stall=1.
  - Edge 1: mem_req rises.
  - If mem_ack arrives in that first request cycle, Stall=0 in that cycle: 1 stall cycle.
- A load miss arriving while WRITE is in flight waits for that write's ack, then issues READ on the next edge.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Reset mid-operation: in-flight transaction abandoned, mem_req=0 the next cycle, buffered stores discarded.

## Test plan
- Reset: hold reset=0 for 2 cycles with MemWrite=1 → mem_req=0, drained=1, Stall=0, count stays 0.
- Single store: push 0x64←7, mem_ack raised on the 3rd request cycle → mem_req=1, mem_we=1, mem_addr=0x64, mem_wdata=7 held stable for 3 cycles. drained=1 one cycle after the ack.
- Forwarding: mem_ack=0, store 0x60←5, store 0x60←9, load 0x60 → ReadData=9, Stall=0. Load 0x62 also returns 9 (bits [1:0] are ignored).
- Full: DEPTH=4, mem_ack=0, 5 consecutive stores → 5th cycle Stall=1. After a single ack, the 5th store is accepted the next cycle and count returns to 4. Drain order is 1-2-3-4-5.
- Load miss behind a write: WRITE to 0x40 in flight, load 0x80, mem_rdata=0xDEADBEEF → Stall=1 through the write ack, then READ with mem_addr=0x80, mem_we=0. Stall=0 and ReadData=0xDEADBEEF in the read ack cycle.
- Reset mid-drain: 3 stores queued, reset=0 during WRITE → next cycle mem_req=0, drained=1, no further writes issued.

Source files
------------

// File: rtl/store_buffer_if.sv
// store_buffer_if: handshaked data-memory bus between the store buffer and memory.
//   mem_req   - transaction valid (driven by master)
//   mem_we    - 1 = write, 0 = read (master)
//   mem_addr  - word-aligned byte address (master)
//   mem_wdata - write data (master)
//   mem_ack   - transaction complete (slave)
//   mem_rdata - read data, valid in the ack cycle of a read (slave)
interface store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between a single-cycle core's data port and
// a slower handshaked memory. Stores are queued in a circular FIFO and drained
// in order; loads hitting the buffer are forwarded combinationally, load misses
// stall the core until memory returns the word.
// Ports:
//   clk       - clock, all state updates on rising edge
//   reset     - synchronous active-low reset
//   MemWrite  - core store request
//   MemRead   - core load request (ignored when MemWrite=1)
//   DataAdr   - core byte address, bits [1:0] ignored
//   WriteData - core store data
//   ReadData  - load data to core
//   Stall     - core must hold this cycle
//   drained   - buffer empty and memory port idle
//   mem       - memory bus (master side)
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  input  logic [AW-1:0]        DataAdr,
  input  logic [DW-1:0]        WriteData,
  output logic [DW-1:0]        ReadData,
  output logic                 Stall,
  output logic                 drained,
  store_buffer_if.master       mem
);
  localparam int PW = $clog2(DEPTH);
  localparam int WA = AW - 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t          state_reg, state_next;
  logic [WA-1:0]   addr_mem [DEPTH];
  logic [DW-1:0]   data_mem [DEPTH];
  logic [PW-1:0]   head_reg, tail_reg;
  logic [PW:0]     count_reg, count_next;
  logic [WA-1:0]   rd_addr_reg;
  logic            latch_rd;

  logic            load, full, push, pop, rd_done;
  logic            hit, miss;
  logic [DW-1:0]   fwd_data;
  logic [DEPTH-1:0] match;            // indexed by age: 0 = head (oldest)
  logic [DW-1:0]   ent_data [DEPTH];  // entry data, same age ordering

  logic            unused_bits;
  assign unused_bits = &{1'b0, DataAdr[1:0]};

  assign load    = reset & MemRead & ~MemWrite;
  assign full    = (count_reg == (PW+1)'(DEPTH));
  // A store against a full buffer is refused even if the head pops this cycle.
  assign push    = reset & MemWrite & ~full;
  assign pop     = (state_reg == WRITE) & mem.mem_ack;
  assign rd_done = (state_reg == READ) & mem.mem_ack;

  // Per-age address compare; the in-flight head stays valid until its ack edge.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PW-1:0] idx;
      assign idx          = head_reg + PW'(gi);
      assign ent_data[gi] = data_mem[idx];
      assign match[gi]    = ((PW+1)'(gi) < count_reg) &&
                            (addr_mem[idx] == DataAdr[AW-1:2]);
    end
  endgenerate

  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match[k]) begin
        hit      = 1'b1;
        fwd_data = ent_data[k];
      end
    end
  end

  assign miss  = load & ~hit;
  assign Stall = reset & ((MemWrite & full) | (miss & ~rd_done));

  always_comb begin
    ReadData = '0;
    if (load && hit) begin
      ReadData = fwd_data;
    end else if (miss && rd_done) begin
      ReadData = mem.mem_rdata;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Memory-port FSM. A pending load miss pre-empts further draining.
  always_comb begin
    state_next = state_reg;
    latch_rd   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (miss) begin
          state_next = READ;
          latch_rd   = 1'b1;
        end else if (count_reg != '0) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (mem.mem_ack) begin
          if (miss) begin
            state_next = READ;
            latch_rd   = 1'b1;
          end else if (count_next != '0) begin
            state_next = WRITE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      READ: begin
        if (mem.mem_ack) begin
          state_next = (count_next != '0) ? WRITE : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      rd_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (push)     tail_reg    <= tail_reg + 1'b1;
      if (pop)      head_reg    <= head_reg + 1'b1;
      if (latch_rd) rd_addr_reg <= DataAdr[AW-1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= DataAdr[AW-1:2];
      data_mem[tail_reg] <= WriteData;
    end
  end

  // Bus outputs depend only on registered state and the head entry, so the
  // payload is stable for the whole request and can change right after an ack.
  always_comb begin
    mem.mem_req   = (state_reg != IDLE);
    mem.mem_we    = (state_reg == WRITE);
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state_reg == WRITE) begin
      mem.mem_addr  = {addr_mem[head_reg], 2'b00};
      mem.mem_wdata = data_mem[head_reg];
    end else if (state_reg == READ) begin
      mem.mem_addr  = {rd_addr_reg, 2'b00};
    end
  end

  assign drained = (count_reg == '0) && (state_reg == IDLE);
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scenario-driven bench for store_buffer. Expected memory
// transactions are queued when stimulus is driven and compared in ack cycles.
module tb_store_buffer;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk;
  logic          reset;
  logic          MemWrite, MemRead;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;
  logic          Stall, drained;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  txn_t sb[$];
  txn_t exp_t;
  int   n_checks = 0;
  int   n_fail   = 0;

  store_buffer_if #(.AW(AW), .DW(DW)) mem_bus ();

  assign mem_bus.mem_ack   = mem_ack;
  assign mem_bus.mem_rdata = mem_rdata;
  assign mem_req           = mem_bus.mem_req;
  assign mem_we            = mem_bus.mem_we;
  assign mem_addr          = mem_bus.mem_addr;
  assign mem_wdata         = mem_bus.mem_wdata;

  store_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .drained   (drained),
    .mem       (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; MemWrite = 1'b1; MemRead = 1'b0;
    DataAdr = 32'h10; WriteData = 32'h1; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall_pre got=%0b exp=0", Stall); end
    cyc(); cyc();
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL reset_drained got=%0b exp=1", drained); end
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%0b exp=0", Stall); end
    n_checks++; if (ReadData !== '0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", ReadData); end
    n_checks++; if (mem_addr !== '0 || mem_wdata !== '0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus got addr=%h wdata=%h we=%0b exp 0/0/0", mem_addr, mem_wdata, mem_we); end
    reset = 1'b1; MemWrite = 1'b0;
    cyc(); #1;
    n_checks++; if (drained !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_store got drained=%0b req=%0b exp 1/0", drained, mem_req); end
  endtask

  task automatic test_single_store();
    MemWrite = 1'b1; DataAdr = 32'h64; WriteData = 32'd7;
    sb.push_back('{1'b1, 32'h64, 32'd7});
    cyc();
    MemWrite = 1'b0; #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL single_latency got req=%0b exp=0", mem_req); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 2); #1;
      n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h64 || mem_wdata !== 32'd7) begin
        n_fail++; $display("FAIL single_hold[%0d] got req=%0b we=%0b addr=%h data=%h exp 1/1/64/7", i, mem_req, mem_we, mem_addr, mem_wdata); end
      if (mem_ack) begin
        exp_t = sb.pop_front();
        n_checks++; if (mem_we !== exp_t.we || mem_addr !== exp_t.addr || mem_wdata !== exp_t.data) begin
          n_fail++; $display("FAIL single_sb got we=%0b addr=%h data=%h exp we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata, exp_t.we, exp_t.addr, exp_t.data); end
        $display("txn single we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata);
      end
      cyc();
    end
    mem_ack = 1'b0; #1;
    n_checks++; if (drained !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL single_drained got drained=%0b req=%0b exp 1/0", drained, mem_req); end
  endtask

  task automatic test_forwarding();
    mem_ack = 1'b0;
    MemWrite = 1'b1; DataAdr = 32'h60; WriteData = 32'd5;
    sb.push_back('{1'b1, 32'h60, 32'd5});
    cyc();
    WriteData = 32'd9;
    sb.push_back('{1'b1, 32'h60, 32'd9});
    cyc();
    MemWrite = 1'b0; MemRead = 1'b1; DataAdr = 32'h60; #1;
    n_checks++; if (ReadData !== 32'd9 || Stall !== 1'b0) begin
      n_fail++; $display("FAIL fwd_youngest got rdata=%h stall=%0b exp 9/0", ReadData, Stall); end
    DataAdr = 32'h62; #1;
    n_checks++; if (ReadData !== 32'd9 || Stall !== 1'b0) begin
      n_fail++; $display("FAIL fwd_lowbits got rdata=%h stall=%0b exp 9/0", ReadData, Stall); end
    DataAdr = 32'h64; #1;
    n_checks++; if (ReadData !== 32'd0 || Stall !== 1'b1) begin
      n_fail++; $display("FAIL fwd_miss got rdata=%h stall=%0b exp 0/1", ReadData, Stall); end
    MemRead = 1'b0;
    for (int k = 0; k < 40 && !drained; k++) begin
      mem_ack = mem_req; #1;
      if (mem_req) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL fwd_sb_extra got addr=%h exp none", mem_addr);
        end else begin
          exp_t = sb.pop_front();
          n_checks++; if (mem_we !== exp_t.we || mem_addr !== exp_t.addr || mem_wdata !== exp_t.data) begin
            n_fail++; $display("FAIL fwd_sb got we=%0b addr=%h data=%h exp we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata, exp_t.we, exp_t.addr, exp_t.data); end
          $display("txn fwd we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata);
        end
      end
      cyc();
      mem_ack = 1'b0; #1;
    end
    n_checks++; if (drained !== 1'b1 || sb.size() != 0) begin
      n_fail++; $display("FAIL fwd_drain got drained=%0b left=%0d exp 1/0", drained, sb.size()); end
  endtask

  task automatic test_full();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MemWrite = 1'b1; DataAdr = 32'h100 + 32'(4 * i); WriteData = 32'(i + 1); #1;
      n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL full_accept[%0d] got stall=%0b exp=0", i, Stall); end
      sb.push_back('{1'b1, DataAdr, WriteData});
      cyc();
    end
    DataAdr = 32'h110; WriteData = 32'd5; #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL full_stall got stall=%0b exp=1", Stall); end
    mem_ack = 1'b1; #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL full_stall_ack got stall=%0b exp=1", Stall); end
    exp_t = sb.pop_front();
    n_checks++; if (mem_we !== exp_t.we || mem_addr !== exp_t.addr || mem_wdata !== exp_t.data) begin
      n_fail++; $display("FAIL full_sb_first got we=%0b addr=%h data=%h exp we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata, exp_t.we, exp_t.addr, exp_t.data); end
    $display("txn full we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata);
    cyc();
    mem_ack = 1'b0; #1;
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL full_retry got stall=%0b exp=0", Stall); end
    sb.push_back('{1'b1, 32'h110, 32'd5});
    cyc();
    DataAdr = 32'h200; WriteData = 32'd6; #1;
    n_checks++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL full_again got stall=%0b exp=1", Stall); end
    MemWrite = 1'b0;
    for (int k = 0; k < 40 && !drained; k++) begin
      mem_ack = mem_req; #1;
      if (mem_req) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL full_sb_extra got addr=%h exp none", mem_addr);
        end else begin
          exp_t = sb.pop_front();
          n_checks++; if (mem_we !== exp_t.we || mem_addr !== exp_t.addr || mem_wdata !== exp_t.data) begin
            n_fail++; $display("FAIL full_sb got we=%0b addr=%h data=%h exp we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata, exp_t.we, exp_t.addr, exp_t.data); end
          $display("txn full we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata);
        end
      end
      cyc();
      mem_ack = 1'b0; #1;
    end
    n_checks++; if (drained !== 1'b1 || sb.size() != 0) begin
      n_fail++; $display("FAIL full_drain got drained=%0b left=%0d exp 1/0", drained, sb.size()); end
  endtask

  task automatic test_miss_behind_write();
    mem_ack = 1'b0;
    MemWrite = 1'b1; DataAdr = 32'h40; WriteData = 32'h11;
    sb.push_back('{1'b1, 32'h40, 32'h11});
    cyc();
    MemWrite = 1'b0;
    cyc();
    MemRead = 1'b1; DataAdr = 32'h80; mem_rdata = 32'hDEADBEEF;
    sb.push_back('{1'b0, 32'h80, 32'h0});
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 2); #1;
      n_checks++; if (Stall !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40) begin
        n_fail++; $display("FAIL miss_wait[%0d] got stall=%0b we=%0b addr=%h exp 1/1/40", i, Stall, mem_we, mem_addr); end
      if (mem_ack) begin
        exp_t = sb.pop_front();
        n_checks++; if (mem_we !== exp_t.we || mem_addr !== exp_t.addr || mem_wdata !== exp_t.data) begin
          n_fail++; $display("FAIL miss_sb_write got we=%0b addr=%h data=%h exp we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata, exp_t.we, exp_t.addr, exp_t.data); end
        $display("txn miss we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata);
      end
      cyc();
    end
    mem_ack = 1'b0; #1;
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h80 || Stall !== 1'b1 || ReadData !== '0) begin
      n_fail++; $display("FAIL miss_read_issue got req=%0b we=%0b addr=%h stall=%0b rdata=%h exp 1/0/80/1/0", mem_req, mem_we, mem_addr, Stall, ReadData); end
    mem_ack = 1'b1; #1;
    n_checks++; if (Stall !== 1'b0 || ReadData !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL miss_read_ack got stall=%0b rdata=%h exp 0/deadbeef", Stall, ReadData); end
    exp_t = sb.pop_front();
    n_checks++; if (mem_we !== exp_t.we || mem_addr !== exp_t.addr || mem_wdata !== exp_t.data) begin
      n_fail++; $display("FAIL miss_sb_read got we=%0b addr=%h data=%h exp we=%0b addr=%h data=%h", mem_we, mem_addr, mem_wdata, exp_t.we, exp_t.addr, exp_t.data); end
    $display("txn miss we=%0b addr=%h data=%h", mem_we, mem_addr, ReadData);
    cyc();
    mem_ack = 1'b0; MemRead = 1'b0; #1;
    n_checks++; if (drained !== 1'b1) begin n_fail++; $display("FAIL miss_drained got=%0b exp=1", drained); end
  endtask

  task automatic test_miss_idle();
    mem_ack = 1'b0;
    MemRead = 1'b1; DataAdr = 32'h200; mem_rdata = 32'h12345678;
    sb.push_back('{1'b0, 32'h200, 32'h0});
    #1;
    n_checks++; if (Stall !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_miss_c0 got stall=%0b req=%0b exp 1/0", Stall, mem_req); end
    cyc();
    mem_ack = 1'b1; #1;
    n_checks++; if (Stall !== 1'b0 || ReadData !== 32'h12345678) begin
      n_fail++; $display("FAIL idle_miss_ack got stall=%0b rdata=%h exp 0/12345678", Stall, ReadData); end
    exp_t = sb.pop_front();
    n_checks++; if (mem_req !== 1'b1 || mem_we !== exp_t.we || mem_addr !== exp_t.addr || mem_wdata !== exp_t.data) begin
      n_fail++; $display("FAIL idle_miss_sb got req=%0b we=%0b addr=%h data=%h exp 1/%0b/%h/%h", mem_req, mem_we, mem_addr, mem_wdata, exp_t.we, exp_t.addr, exp_t.data); end
    $display("txn idle_miss we=%0b addr=%h data=%h", mem_we, mem_addr, ReadData);
    cyc();
    mem_ack = 1'b0; MemRead = 1'b0; #1;
    n_checks++; if (drained !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_miss_done got drained=%0b req=%0b exp 1/0", drained, mem_req); end
  endtask

  task automatic test_reset_mid_drain();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      MemWrite = 1'b1; DataAdr = 32'h300 + 32'(4 * i); WriteData = 32'(32'hA0 + i);
      cyc();
    end
    MemWrite = 1'b0; #1;
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL mid_inflight got req=%0b we=%0b exp 1/1", mem_req, mem_we); end
    reset = 1'b0; MemRead = 1'b1; DataAdr = 32'h700; #1;
    n_checks++; if (Stall !== 1'b0 || ReadData !== '0) begin
      n_fail++; $display("FAIL mid_reset_comb got stall=%0b rdata=%h exp 0/0", Stall, ReadData); end
    cyc();
    reset = 1'b1; MemRead = 1'b0; #1;
    n_checks++; if (mem_req !== 1'b0 || drained !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_after got req=%0b drained=%0b exp 0/1", mem_req, drained); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (mem_req !== 1'b0) begin
        n_fail++; $display("FAIL mid_no_write[%0d] got req=%0b exp=0", i, mem_req); end
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_forwarding();
    test_full();
    test_miss_behind_write();
    test_miss_idle();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
